// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: instruction class encoding,
// the decoded bundle layout and ALU opcode names.
package decode_pkg;

  typedef enum logic [1:0] {
    CLS_DP    = 2'b00,
    CLS_MEM   = 2'b01,
    CLS_BR    = 2'b10,
    CLS_UNDEF = 2'b11
  } cls_e;

  localparam logic [3:0] FUNC_AND = 4'h0;
  localparam logic [3:0] FUNC_EOR = 4'h1;
  localparam logic [3:0] FUNC_SUB = 4'h2;
  localparam logic [3:0] FUNC_RSB = 4'h3;
  localparam logic [3:0] FUNC_ADD = 4'h4;
  localparam logic [3:0] FUNC_ADC = 4'h5;
  localparam logic [3:0] FUNC_SBC = 4'h6;
  localparam logic [3:0] FUNC_RSC = 4'h7;
  localparam logic [3:0] FUNC_TST = 4'h8;
  localparam logic [3:0] FUNC_TEQ = 4'h9;
  localparam logic [3:0] FUNC_CMP = 4'hA;
  localparam logic [3:0] FUNC_CMN = 4'hB;
  localparam logic [3:0] FUNC_ORR = 4'hC;
  localparam logic [3:0] FUNC_MOV = 4'hD;
  localparam logic [3:0] FUNC_BIC = 4'hE;
  localparam logic [3:0] FUNC_MVN = 4'hF;

  // Control fields of the bundle; the immediate is carried separately because
  // its width follows the DATA_W parameter of the instantiating module.
  typedef struct packed {
    logic [3:0] cond;
    cls_e       cls;
    logic       use_imm;
    logic       use_mem;
    logic       w_mem;
    logic       mem_up;
    logic       set_flags;
    logic       link;
    logic       undef;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rm;
    logic [3:0] func;
  } decoded_t;

  function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amount);
    logic [5:0] back;
    back = 6'd32 - {1'b0, amount};
    return (value >> amount) | (value << back);
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: raw 32-bit word to control
// bundle plus expanded immediate / branch offset.
module decode_comb
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instruction,
  output decoded_t          dec,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    dec      = '0;
    imm      = '0;
    dec.cond = instruction[31:28];
    dec.cls  = cls_e'(instruction[27:26]);
    unique case (dec.cls)
      CLS_DP: begin
        dec.rd        = instruction[15:12];
        dec.rs        = instruction[19:16];
        dec.func      = instruction[24:21];
        dec.set_flags = instruction[20];
        dec.use_imm   = instruction[25];
        if (instruction[25]) begin
          // Rotate amount is encoded in units of two bit positions.
          imm = DATA_W'(ror32({24'd0, instruction[7:0]}, {instruction[11:8], 1'b0}));
        end else begin
          dec.rm = instruction[3:0];
        end
      end
      CLS_MEM: begin
        dec.use_mem = 1'b1;
        dec.rd      = instruction[15:12];
        dec.rs      = instruction[19:16];
        dec.w_mem   = !instruction[20];
        dec.mem_up  = instruction[23];
        dec.use_imm = instruction[25];
        if (instruction[25]) begin
          imm = DATA_W'(instruction[11:0]);
        end else begin
          dec.rm = instruction[3:0];
        end
      end
      CLS_BR: begin
        dec.link    = instruction[24];
        dec.use_imm = 1'b1;
        imm         = {{(DATA_W-26){instruction[23]}}, instruction[23:0], 2'b00};
      end
      default: begin
        dec.undef = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, optional skid entry for
// full throughput under backpressure, and a synchronous flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [PC_W-1:0]   pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [3:0]        cond,
  output logic [1:0]        cls,
  output logic              use_imm,
  output logic              use_mem,
  output logic              w_mem,
  output logic              mem_up,
  output logic              set_flags,
  output logic              link,
  output logic              undef,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rm,
  output logic [3:0]        func,
  output logic [DATA_W-1:0] imm
);

  decoded_t          new_dec;
  logic [DATA_W-1:0] new_imm;

  decoded_t          out_dec_q, out_dec_d, skid_dec_q, skid_dec_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic              accept;

  decode_comb #(.DATA_W(DATA_W)) u_decode_comb (
    .instruction (instruction),
    .dec         (new_dec),
    .imm         (new_imm)
  );

  assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_dec_d    = out_dec_q;
    out_imm_d    = out_imm_q;
    out_pc_d     = out_pc_q;
    skid_dec_d   = skid_dec_q;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot is free or draining; the skid entry is older, so it goes first.
      if (skid_valid_q) begin
        out_dec_d    = skid_dec_q;
        out_imm_d    = skid_imm_q;
        out_pc_d     = skid_pc_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_dec_d   = new_dec;
        out_imm_d   = new_imm;
        out_pc_d    = pc_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_dec_d   = new_dec;
      skid_imm_d   = new_imm;
      skid_pc_d    = pc_in;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_dec_q    <= '0;
      out_imm_q    <= '0;
      out_pc_q     <= '0;
      skid_dec_q   <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_dec_q    <= out_dec_d;
      out_imm_q    <= out_imm_d;
      out_pc_q     <= out_pc_d;
      skid_dec_q   <= skid_dec_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = out_pc_q;
  assign imm       = out_imm_q;
  assign cond      = out_dec_q.cond;
  assign cls       = out_dec_q.cls;
  assign use_imm   = out_dec_q.use_imm;
  assign use_mem   = out_dec_q.use_mem;
  assign w_mem     = out_dec_q.w_mem;
  assign mem_up    = out_dec_q.mem_up;
  assign set_flags = out_dec_q.set_flags;
  assign link      = out_dec_q.link;
  assign undef     = out_dec_q.undef;
  assign rd        = out_dec_q.rd;
  assign rs        = out_dec_q.rs;
  assign rm        = out_dec_q.rm;
  assign func      = out_dec_q.func;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode of each instruction
// class, skid ordering under backpressure, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [3:0]  cond;
  logic [1:0]  cls;
  logic        use_imm, use_mem, w_mem, mem_up, set_flags, link, undef;
  logic [3:0]  rd, rs, rm, func;
  logic [31:0] imm;

  int assertCount = 0;
  int failCount   = 0;

  decode_stage #(.DATA_W(32), .PC_W(32), .SKID(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .pc_in       (pc_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pc_out      (pc_out),
    .cond        (cond),
    .cls         (cls),
    .use_imm     (use_imm),
    .use_mem     (use_mem),
    .w_mem       (w_mem),
    .mem_up      (mem_up),
    .set_flags   (set_flags),
    .link        (link),
    .undef       (undef),
    .rd          (rd),
    .rs          (rs),
    .rm          (rm),
    .func        (func),
    .imm         (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one input beat at the falling edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid    = valid;
    instruction = instr;
    pc_in       = pc;
  endtask

  // Packs every decoded field into one word: {cond,cls,use_imm,use_mem,w_mem,mem_up,set_flags,link,undef,rd,rs,rm,func}
  function automatic logic [28:0] packFields();
    return {cond, cls, use_imm, use_mem, w_mem, mem_up, set_flags, link, undef, rd, rs, rm, func};
  endfunction

  function automatic logic [28:0] expFields(input logic [3:0] c, input logic [1:0] k, input logic ui, input logic um,
                                            input logic wm, input logic up, input logic sf, input logic lk,
                                            input logic ud, input logic [3:0] d, input logic [3:0] s,
                                            input logic [3:0] m, input logic [3:0] f);
    return {c, k, ui, um, wm, up, sf, lk, ud, d, s, m, f};
  endfunction

  // Send one instruction with out_ready high, then check the bundle one cycle later.
  task automatic decodeOne(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [28:0] fields, input logic [31:0] expImm);
    applyStimulus(1'b1, instr, pc);
    applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput({tag, ".valid"}, out_valid, 1'b1);
    checkOutput({tag, ".fields"}, packFields(), fields);
    checkOutput({tag, ".imm"}, imm, expImm);
    checkOutput({tag, ".pc"}, pc_out, pc);
  endtask

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    instruction = 32'd0;
    pc_in       = 32'd0;
    out_ready   = 1'b1;

    #12;
    checkOutput("rst.out_valid", out_valid, 1'b0);
    checkOutput("rst.fields", packFields(), 29'd0);
    checkOutput("rst.imm", imm, 32'd0);
    checkOutput("rst.pc", pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst.in_ready", in_ready, 1'b1);
    checkOutput("rst.idle", out_valid, 1'b0);

    decodeOne("mov", 32'hE3A01005, 32'h1000,
              expFields(4'hE, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'd1, 4'd0, 4'd0, 4'hD), 32'h5);
    decodeOne("add_imm", 32'hE2811C01, 32'h1004,
              expFields(4'hE, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'd1, 4'd1, 4'd0, 4'h4), 32'h100);
    decodeOne("add_reg", 32'hE0813002, 32'h1008,
              expFields(4'hE, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd3, 4'd1, 4'd2, 4'h4), 32'h0);
    decodeOne("ldr", 32'hE7932008, 32'h100C,
              expFields(4'hE, 2'b01, 1, 1, 0, 1, 0, 0, 0, 4'd2, 4'd3, 4'd0, 4'h0), 32'h8);
    decodeOne("str_reg", 32'hE5032004, 32'h1010,
              expFields(4'hE, 2'b01, 0, 1, 1, 0, 0, 0, 0, 4'd2, 4'd3, 4'd4, 4'h0), 32'h0);
    decodeOne("bl", 32'hEBFFFFFE, 32'h1014,
              expFields(4'hE, 2'b10, 1, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'h0), 32'hFFFFFFF8);
    decodeOne("undef", 32'hEC000000, 32'h1018,
              expFields(4'hE, 2'b11, 0, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'h0), 32'h0);
    @(negedge clk);
    checkOutput("drain.out_valid", out_valid, 1'b0);

    // Backpressure: A fills output, B fills skid, C is held off.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hE3A01005, 32'h200);
    applyStimulus(1'b1, 32'hE2811C01, 32'h204);
    checkOutput("skid.ready_after_a", in_ready, 1'b1);
    applyStimulus(1'b1, 32'hE7932008, 32'h208);
    checkOutput("skid.ready_after_b", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("skid.held_ready", in_ready, 1'b0);
    checkOutput("skid.held_pc", pc_out, 32'h200);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("skid.second_pc", pc_out, 32'h204);
    checkOutput("skid.second_imm", imm, 32'h100);
    checkOutput("skid.second_valid", out_valid, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("skid.third_pc", pc_out, 32'h208);
    checkOutput("skid.third_rd", rd, 4'd2);
    checkOutput("skid.third_valid", out_valid, 1'b1);
    @(negedge clk);
    checkOutput("skid.empty", out_valid, 1'b0);

    // Flush with both entries occupied and a pending input.
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hE3A01005, 32'h300);
    applyStimulus(1'b1, 32'hE2811C01, 32'h304);
    applyStimulus(1'b1, 32'hE7932008, 32'h308);
    checkOutput("flush.full_ready", in_ready, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush.out_valid", out_valid, 1'b0);
    checkOutput("flush.in_ready", in_ready, 1'b1);
    @(negedge clk);
    checkOutput("flush.stays_empty", out_valid, 1'b0);

    // Asynchronous reset while a bundle is being held.
    applyStimulus(1'b1, 32'hEBFFFFFE, 32'h400);
    applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput("arst.before", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst.out_valid", out_valid, 1'b0);
    checkOutput("arst.imm", imm, 32'd0);
    checkOutput("arst.link", link, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("arst.no_emit", out_valid, 1'b0);
    end
    checkOutput("arst.in_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised instruction decoder sitting between fetch and register-read/execute.
- Accepts one 32-bit instruction plus its PC per valid/ready handshake.
- Produces a fully registered decoded bundle: condition, class, register fields, expanded immediate, memory/branch control and an undefined-instruction flag.
- Supports backpressure through an optional skid buffer, plus a synchronous flush for taken branches.

Parameters:
- DATA_W, 32: width of the immediate output and the sign-extended branch offset; must be ≥ 32.
- PC_W, 32: width of the pc_in/pc_out sideband.
- SKID, 1: 1 = two-entry (output + skid) buffer, full throughput under backpressure; 0 = single output register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- flush  in  1  synchronous; drops all held entries.
- in_valid  in  1  instruction/pc_in valid.
- in_ready  out  1  stage can accept this cycle.
- instruction  in  32  raw instruction word.
- pc_in  in  PC_W  address of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts this cycle.
- pc_out  out  PC_W  PC of the bundle.
- cond  out  4  instruction[31:28].
- cls  out  2  instruction[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined.
- use_imm  out  1  operand 2 is imm.
- use_mem  out  1  memory access.
- w_mem  out  1  memory write (store).
- mem_up  out  1  offset added (1) or subtracted (0).
- set_flags  out  1  data-proc S bit.
- link  out  1  branch-with-link.
- undef  out  1  cls == 11.
- rd, rs, rm  out  4 each  destination, operand 1, operand 2 registers.
- func  out  4  ALU opcode.
- imm  out  DATA_W  expanded immediate or branch offset.

Behaviour:
- Reset (async, reset=0):
  - out_valid=0, skid entry empty.
  - All bundle outputs 0.
  - in_ready=1 from the first edge after release.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_valid/instruction must stay stable while in_valid=1 and in_ready=0.
  - Latency is 1 cycle: an accepted instruction appears on the outputs the next cycle when the output register is empty or draining.
- SKID=1:
  - in_ready = !skid_valid (registered).
  - An accept while the output is held (out_valid & !out_ready) writes the skid entry.
  - On the next out transfer, the skid entry moves to the output register and the skid is freed.
  - Simultaneous accept and out transfer with the skid empty: the new bundle replaces the output entry.
  - Order is preserved; no drop or duplicate.
- SKID=0: in_ready = !out_valid | out_ready (combinational from out_ready).
- flush:
  - Next cycle out_valid=0 and skid empty.
  - An input accepted in the same cycle as flush is discarded.
  - flush has priority over every other update.
- Decode, data-proc (cls 00):
  - rd=[15:12], rs=[19:16], func=[24:21], set_flags=[20].
  - [25]=1: use_imm=1, rm=0, imm = zero-extend(ror32([7:0], 2*[11:8])).
  - [25]=0: use_imm=0, rm=[3:0], imm=0.
  - use_mem=0, w_mem=0.
- Decode, memory (cls 01):
  - use_mem=1, rd=[15:12], rs=[19:16], func=0.
  - L=[20]: w_mem = !L.
  - mem_up=[23].
  - [25]=1: use_imm=1, rm=0, imm = zero-extend([11:0]).
  - [25]=0: use_imm=0, rm=[3:0], imm=0.
- Decode, branch (cls 10):
  - link=[24], use_imm=1.
  - imm = sign-extend([23:0]) << 2 to DATA_W.
  - rd/rs/rm/func = 0.
- Decode, cls 11: undef=1; all other fields except cond and pc_out are 0.
- Unused flags for a class are 0.

Decomposition:
- Shared package decode_pkg:
  - typedef enum for cls (CLS_DP, CLS_MEM, CLS_BR, CLS_UNDEF).
  - packed struct decoded_t for the bundle.
  - ALU func constants (e.g. FUNC_ADD=4'h4, FUNC_MOV=4'hD).
- Sub-module decode_comb: purely combinational instruction → decoded_t.
- decode_stage holds the handshake, skid buffer and flush logic around it.

Test Plan:
- MOV r1,#5 (0xE3A01005) → next cycle:
  - cond=E, cls=00, use_imm=1, func=D, rd=1, imm=5, set_flags=0.
- ADD r1,r1,#0x100 (0xE2811C01) → rotate expansion gives imm=0x00000100, func=4, rs=1.
- Load-with-immediate (0xE7932008) → use_mem=1, w_mem=0, mem_up=1, rd=2, rs=3, imm=8.
- BL (0xEBFFFFFE) → cls=10, link=1, imm=0xFFFFFFF8.
- 0xEC000000 → undef=1, cond=E, all other fields 0.
- SKID=1, out_ready=0, three back-to-back instructions:
  - in_ready drops after the 2nd is accepted; the 3rd is held.
  - Releasing out_ready delivers all three in order, one per cycle.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1.
- Async reset mid-stream → out_valid=0 immediately; nothing emitted after release until new input.
